// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams, with packet lock.
// Define UART_ARB_PRIO_EN to give requester 0 strict priority whenever no lock is held.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned GAP_CYCLES   = 0,
    parameter int unsigned LOCK_TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            tx_en,
    output logic [PAYLOAD_BITS-1:0]         tx_data,
    input  logic                            tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            locked
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    typedef enum logic [1:0] {ARB, LAUNCH, DRAIN, GAP} state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]           grant_id_q, grant_id_d;
    logic                    locked_q, locked_d;
    logic                    tx_en_q, tx_en_d;
    logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
    logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;

    logic [NUM_REQ-1:0]      eligible;
    logic [IW-1:0]           win_idx;
    logic                    win_found;
    logic                    xfer;
    logic                    lock_count;
    logic                    lock_expire;

    // Winner search starts just after the last grantee, so a finished owner drops to lowest priority.
    always_comb begin
        logic [IW-1:0] idx;
        idx       = '0;
        eligible  = locked_q ? (req_valid & (NUM_REQ'(1) << grant_id_q)) : req_valid;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
`ifdef UART_ARB_PRIO_EN
        if (!locked_q && req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
    end

    assign xfer        = resetn && (state_q == ARB) && !tx_busy && win_found;
    assign lock_count  = (LOCK_TIMEOUT != 0) && (state_q == ARB) && locked_q && !req_valid[grant_id_q];
    assign lock_expire = lock_count && (to_cnt_q == TW'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (xfer) state_d = LAUNCH;
            LAUNCH:  state_d = DRAIN;
            DRAIN:   if (!tx_busy) state_d = (GAP_CYCLES > 0) ? GAP : ARB;
            GAP:     if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[win_idx] = 1'b1;
    end

    always_comb begin
        tx_en_d    = xfer;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        locked_d   = locked_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = (state_q == GAP && state_d == GAP) ? gap_cnt_q + 1'b1 : '0;
        if (xfer) begin
            tx_data_d  = req_data[32'(win_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
            grant_id_d = win_idx;
            rr_ptr_d   = win_idx;
            locked_d   = !req_last[win_idx];
            to_cnt_d   = '0;
        end else if (lock_expire) begin
            locked_d = 1'b0;
            to_cnt_d = '0;
        end else if (lock_count) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= IW'(NUM_REQ - 1);
            locked_q   <= 1'b0;
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            locked_q   <= locked_d;
            gap_cnt_q  <= gap_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues, a fixed-length transmitter
// model, and a reference arbiter derived from the grant/lock/spacing rules.
module tb_uart_tx_arbiter;

    localparam int NR = 4, PB = 8, GAP = 5, TO = 4, FRAME = 10;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NR-1:0]     req_valid, req_last, req_ready;
    logic [NR*PB-1:0]  req_data;
    logic              tx_en, tx_busy, locked;
    logic [PB-1:0]     tx_data;
    logic [1:0]        grant_id;

    uart_tx_arbiter #(.NUM_REQ(NR), .PAYLOAD_BITS(PB), .GAP_CYCLES(GAP), .LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_id(grant_id), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [7:0] d; int id; bit lk; } exp_t;

    int         checks = 0, errors = 0, cyc = 0, n_tx = 0, tcnt = 0;
    exp_t       sb[$];
    exp_t       e;
    logic [8:0] rq [NR][$];
    int         order_q[$], acc_cyc[$];
    bit         rst_req, ext_req, ext_busy, throttle;
    int         m_ptr, m_owner, m_tocnt, m_next_ok;
    bit         m_lock;
    logic       s_tx_en, s_locked;
    logic [NR-1:0] s_ready;
    logic [7:0] s_tx_data, last_data;
    logic [1:0] s_gid;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: busy for FRAME cycles starting the cycle after it sees tx_en.
    always @(posedge clk) begin
        if (!resetn) tcnt <= 0;
        else if (tx_en) tcnt <= FRAME;
        else if (tcnt != 0) tcnt <= tcnt - 1;
    end
    assign tx_busy = (tcnt != 0) || ext_busy;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_ptr = NR - 1; m_owner = 0; m_lock = 0; m_tocnt = 0; m_next_ok = 0;
        sb.delete();
    endfunction

    function automatic int pick(input logic [NR-1:0] v);
        logic [NR-1:0] elig;
        elig = m_lock ? (v & (NR'(1) << m_owner)) : v;
`ifdef UART_ARB_PRIO_EN
        if (!m_lock && v[0]) return 0;
`endif
        for (int k = 1; k <= NR; k++) begin
            if (elig[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic cycle();
        logic [NR-1:0] v, exp_rdy, acc;
        logic [8:0]    h;
        int            w;
        @(negedge clk);
        resetn = rst_req;
        ext_busy = ext_req;
        v = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() != 0 && (!throttle || $urandom_range(3) != 0)) begin
                h = rq[i][0];
                v[i] = 1'b1;
                req_data[i*PB +: PB] = h[7:0];
                req_last[i] = h[8];
            end
        end
        req_valid = v;
        #1;
        s_tx_en = tx_en; s_locked = locked; s_ready = req_ready; s_tx_data = tx_data; s_gid = grant_id;
        if (resetn) begin
            chk("locked", 32'(locked), 32'(m_lock));
            chk("grant_id", 32'(grant_id), 32'(m_owner));
        end
        exp_rdy = '0;
        w = -1;
        if (resetn && cyc >= m_next_ok) begin
            if (!tx_busy) w = pick(v);
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        acc = v & req_ready;
        if (w >= 0) begin
            h = rq[w][0];
            sb.push_back('{cyc + 1, h[7:0], w, !h[8]});
            m_ptr = w; m_owner = w; m_lock = !h[8]; m_tocnt = 0;
            m_next_ok = cyc + FRAME + GAP + 3;
        end else if (resetn && cyc >= m_next_ok && m_lock && !v[m_owner] && TO != 0) begin
            m_tocnt++;
            if (m_tocnt == TO) begin m_lock = 0; m_tocnt = 0; end
        end
        @(posedge clk);
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                void'(rq[i].pop_front());
                order_q.push_back(i);
                acc_cyc.push_back(cyc);
            end
        end
        if (!resetn) model_reset();
    endtask

    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            n_tx++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_en_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("tx_cycle", 32'(cyc), 32'(e.cyc));
                chk("tx_data", 32'(tx_data), 32'(e.d));
                chk("tx_grant_id", 32'(grant_id), 32'(e.id));
                chk("tx_locked", 32'(locked), 32'(e.lk));
                last_data = tx_data;
            end
        end
    end

    function automatic bool_busy();
        int pend = 0;
        for (int i = 0; i < NR; i++) pend += rq[i].size();
        return (pend != 0) || (sb.size() != 0) || (cyc <= m_next_ok);
    endfunction

    task automatic run_idle(input int maxc);
        int n = 0;
        while (bool_busy() && n < maxc) begin cycle(); n++; end
        chk("idle_reached", 32'(bool_busy()), 32'(0));
    endtask

    task automatic run_until_acc(input int k);
        int n = 0;
        while (order_q.size() < k && n < 300) begin cycle(); n++; end
        chk("acc_wait", 32'(order_q.size() >= k), 32'(1));
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit last);
        rq[r].push_back({last, d});
    endtask

    task automatic check_order(input string name, input int exp[$]);
        chk({name, "_len"}, 32'(order_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < order_q.size(); i++)
            chk(name, 32'(order_q[i]), 32'(exp[i]));
        order_q.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int ex[$];
        resetn = 1'b0; rst_req = 1'b0; ext_req = 1'b0; ext_busy = 1'b0; throttle = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        model_reset();
        repeat (3) cycle();
        rst_req = 1'b1;
        cycle();
        chk("reset_tx_en", 32'(s_tx_en), 0);
        chk("reset_tx_data", 32'(s_tx_data), 0);
        chk("reset_ready", 32'(s_ready), 0);
        chk("reset_grant_id", 32'(s_gid), 0);
        chk("reset_locked", 32'(s_locked), 0);

        // Three contenders, all single-byte packets
        n_tx = 0;
        for (int k = 0; k < 2; k++) begin
            push(0, 8'($urandom), 1'b1); push(2, 8'($urandom), 1'b1); push(3, 8'($urandom), 1'b1);
        end
        run_idle(400);
        ex = '{0, 2, 3, 0, 2, 3};
        check_order("order_rr", ex);
        chk("tx_pulses", 32'(n_tx), 6);

        push(1, 8'hA5, 1'b1);
        run_idle(100);
        ex = '{1};
        check_order("order_single", ex);
        chk("single_data", 32'(last_data), 32'h A5);

        // Locked 3-byte packet from 1 while 0 waits
        push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
        run_until_acc(1);
        push(0, 8'h44, 1'b1);
        run_idle(300);
        ex = '{1, 1, 1, 0};
        check_order("order_lock", ex);

        // Owner abandons an open packet: lock times out
        push(2, 8'h55, 1'b0);
        run_until_acc(1);
        push(0, 8'h66, 1'b1);
        run_idle(300);
        chk("timeout_delta", 32'(acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1), 32'(FRAME + GAP + 3 + TO));
        ex = '{2, 0};
        check_order("order_timeout", ex);

        // External transmitter activity holds off arbitration
        ext_req = 1'b1;
        push(3, 8'h77, 1'b1);
        repeat (6) cycle();
        chk("ext_busy_ready", 32'(s_ready), 0);
        ext_req = 1'b0;
        run_idle(100);
        ex = '{3};
        check_order("order_ext", ex);

        // Reset while draining a locked byte
        push(1, 8'h88, 1'b0);
        run_until_acc(1);
        repeat (4) cycle();
        push(0, 8'h99, 1'b1);
        rst_req = 1'b0;
        repeat (2) cycle();
        chk("rst_drain_tx_en", 32'(s_tx_en), 0);
        chk("rst_drain_locked", 32'(s_locked), 0);
        chk("rst_drain_ready", 32'(s_ready), 0);
        rst_req = 1'b1;
        run_idle(100);
        ex = '{1, 0};
        check_order("order_rst", ex);

        for (int k = 0; k < 3; k++) begin
            push(0, 8'($urandom), 1'b1); push(3, 8'($urandom), 1'b1);
        end
        run_idle(300);
`ifdef UART_ARB_PRIO_EN
        ex = '{0, 0, 0, 3, 3, 3};
`else
        ex = '{3, 0, 3, 0, 3, 0};
`endif
        check_order("order_prio", ex);

        // Randomized traffic with valid throttling
        throttle = 1'b1;
        for (int k = 0; k < 80; k++)
            push($urandom_range(NR - 1), 8'($urandom), $urandom_range(2) != 0);
        run_idle(20000);
        throttle = 1'b0;
        order_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
